// File: rtl/layer0_input_packer.sv
// Quantizes a serial stream of unsigned cell energies to 2-bit levels and packs a
// full frame into one wide double-buffered vector for the first LUT layer.
module layer0_input_packer #(
    parameter int                NUM_FEATURES = 48,
    parameter int                IN_W         = 8,
    parameter int                OUT_BW       = 2,
    parameter logic [IN_W-1:0]   TH0          = IN_W'(64),
    parameter logic [IN_W-1:0]   TH1          = IN_W'(128),
    parameter logic [IN_W-1:0]   TH2          = IN_W'(192)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [IN_W-1:0]                s_data,
    input  logic                           s_last,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [NUM_FEATURES*OUT_BW-1:0] m_data,
    output logic                           frame_err
);

    localparam int FW = NUM_FEATURES * OUT_BW;
    localparam int CW = $clog2(NUM_FEATURES);
    localparam logic [CW-1:0] LAST_SLOT = CW'(NUM_FEATURES - 1);

    typedef enum logic {ASSEMBLE, HOLD} state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [FW-1:0]       asm_reg;
    logic [FW-1:0]       asm_next;
    logic [OUT_BW-1:0]   q;
    logic                xfer;
    logic                last_slot;
    logic                bad_frame;

    // A sample equal to a threshold lands on the upper level.
    always_comb begin
        q = OUT_BW'(3);
        if (s_data < TH0)
            q = OUT_BW'(0);
        else if (s_data < TH1)
            q = OUT_BW'(1);
        else if (s_data < TH2)
            q = OUT_BW'(2);
    end

    always_comb begin
        asm_next = asm_reg;
        for (int k = 0; k < NUM_FEATURES; k++) begin
            if (cnt == CW'(k))
                asm_next[k*OUT_BW +: OUT_BW] = q;
        end
    end

    assign s_ready   = (state == ASSEMBLE);
    assign xfer      = s_valid && s_ready;
    assign last_slot = (cnt == LAST_SLOT);
    assign bad_frame = (last_slot != s_last);

    // HOLD keeps the completed frame in the assembly register until the output
    // buffer frees up; every slot is rewritten per frame, so no clear is needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ASSEMBLE;
            cnt       <= '0;
            asm_reg   <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (m_valid && m_ready)
                m_valid <= 1'b0;

            if (state == HOLD) begin
                if (m_ready) begin
                    m_data  <= asm_reg;
                    m_valid <= 1'b1;
                    state   <= ASSEMBLE;
                end
            end else if (xfer) begin
                if (bad_frame) begin
                    frame_err <= 1'b1;
                    cnt       <= '0;
                end else if (s_last) begin
                    cnt <= '0;
                    if (!m_valid || m_ready) begin
                        m_data  <= asm_next;
                        m_valid <= 1'b1;
                    end else begin
                        asm_reg <= asm_next;
                        state   <= HOLD;
                    end
                end else begin
                    asm_reg <= asm_next;
                    cnt     <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_layer0_input_packer.sv
// Checks the packer with a 4-feature instance (vector table plus reset sequence)
// and a default 48-feature instance streaming back-to-back frames.
module tb_layer0_input_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = '0;
    logic        s_last = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [7:0]  m_data;
    logic        frame_err;

    logic        t_valid = 1'b0;
    logic        t_ready;
    logic [7:0]  t_data = '0;
    logic        t_last = 1'b0;
    logic        t_mvalid;
    logic        t_mready = 1'b1;
    logic [95:0] t_mdata;
    logic        t_err;

    int test_count = 0;
    int fail_count = 0;

    typedef struct {
        int v; int d; int l; int mr;
        int es; int emv; int emd; int ee;
    } vec_t;

    vec_t        tbl[$];
    logic [95:0] sb[$];

    always #5 clk = ~clk;

    layer0_input_packer #(.NUM_FEATURES(4)) dut4 (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .frame_err(frame_err)
    );

    layer0_input_packer dut48 (
        .clk(clk), .rst(rst),
        .s_valid(t_valid), .s_ready(t_ready), .s_data(t_data), .s_last(t_last),
        .m_valid(t_mvalid), .m_ready(t_mready), .m_data(t_mdata), .frame_err(t_err)
    );

    function automatic vec_t mk(int v, int d, int l, int mr, int es, int emv, int emd, int ee);
        vec_t r;
        r.v = v; r.d = d; r.l = l; r.mr = mr;
        r.es = es; r.emv = emv; r.emd = emd; r.ee = ee;
        return r;
    endfunction

    function automatic logic [1:0] qmodel(int d);
        if (d < 64)  return 2'd0;
        if (d < 128) return 2'd1;
        if (d < 192) return 2'd2;
        return 2'd3;
    endfunction

    task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
        test_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int v, input int d, input int l, input int mr);
        s_valid = 1'(v);
        s_data  = 8'(d);
        s_last  = 1'(l);
        m_ready = 1'(mr);
        @(posedge clk);
        #1;
    endtask

    task automatic checkStep(input string tag, input vec_t t);
        checkOutput({tag, " s_ready"},   96'(s_ready),   96'(t.es));
        checkOutput({tag, " m_valid"},   96'(m_valid),   96'(t.emv));
        checkOutput({tag, " frame_err"}, 96'(frame_err), 96'(t.ee));
        if (t.emv != 0)
            checkOutput({tag, " m_data"}, 96'(m_data), 96'(t.emd));
    endtask

    int          cyc;
    int          last_mv;
    int          frames_seen;

    task automatic monitor48();
        checkOutput("tput frame_err", 96'(t_err), 96'(0));
        if (t_mvalid) begin
            if (sb.size() == 0) begin
                checkOutput("tput unexpected frame", 96'(1), 96'(0));
            end else begin
                checkOutput($sformatf("tput frame %0d data", frames_seen), t_mdata, sb.pop_front());
            end
            if (last_mv >= 0)
                checkOutput("tput frame spacing", 96'(cyc - last_mv), 96'(48));
            last_mv = cyc;
            frames_seen++;
        end
    endtask

    initial begin
        logic [95:0] exp_frame;
        int          d;

        // quantizer boundaries
        tbl.push_back(mk(1, 63, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 64, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 191, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 192, 1, 1, 1, 1, 8'hE4, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0));
        // backpressure: frame A held, frame B parks in HOLD
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 200, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 200, 1, 0, 1, 1, 8'hFF, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 0, 0, 1, 1, 8'hFF, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 1, 8'hFF, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 8'hFF, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 8'h00, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0));
        // short frame then a good one
        tbl.push_back(mk(1, 10, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 10, 1, 1, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 10, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 70, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 130, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 250, 1, 1, 1, 1, 8'hE4, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0));
        // missing last then a good one
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 250, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 250, 0, 1, 1, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 250, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 250, 1, 1, 1, 1, 8'hCC, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0));
        // completion on the same edge the full buffer drains
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 200, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 200, 1, 0, 1, 1, 8'hFF, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 8'hFF, 0));
        tbl.push_back(mk(1, 64, 0, 0, 1, 1, 8'hFF, 0));
        tbl.push_back(mk(1, 128, 0, 0, 1, 1, 8'hFF, 0));
        tbl.push_back(mk(1, 192, 1, 1, 1, 1, 8'hE4, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset s_ready",   96'(s_ready),   96'(1));
        checkOutput("reset m_valid",   96'(m_valid),   96'(0));
        checkOutput("reset m_data",    96'(m_data),    96'(0));
        checkOutput("reset frame_err", 96'(frame_err), 96'(0));
        checkOutput("reset48 s_ready", 96'(t_ready),   96'(1));
        checkOutput("reset48 m_valid", 96'(t_mvalid),  96'(0));
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].mr);
            checkStep($sformatf("step %0d", i), tbl[i]);
        end

        // async reset mid-frame with a frame pending on the output
        for (int i = 0; i < 4; i++) applyStimulus(1, 200, (i == 3) ? 1 : 0, 0);
        checkOutput("arst pre m_valid", 96'(m_valid), 96'(1));
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        s_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        checkOutput("arst m_valid",   96'(m_valid),   96'(0));
        checkOutput("arst s_ready",   96'(s_ready),   96'(1));
        checkOutput("arst m_data",    96'(m_data),    96'(0));
        checkOutput("arst frame_err", 96'(frame_err), 96'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1, 0, 0, 1);
        checkOutput("arst post frame_err", 96'(frame_err), 96'(0));
        applyStimulus(1, 64, 0, 1);
        applyStimulus(1, 128, 0, 1);
        applyStimulus(1, 192, 1, 1);
        checkOutput("arst frame m_valid", 96'(m_valid), 96'(1));
        checkOutput("arst frame m_data",  96'(m_data),  96'(8'hE4));
        applyStimulus(0, 0, 0, 1);

        // back-to-back 48-feature frames, expectations queued at the last sample
        cyc = 0;
        last_mv = -1;
        frames_seen = 0;
        t_mready = 1'b1;
        for (int f = 0; f < 10; f++) begin
            exp_frame = '0;
            for (int k = 0; k < 48; k++) begin
                d = int'($urandom_range(0, 255));
                exp_frame[k*2 +: 2] = qmodel(d);
                if (k == 47) sb.push_back(exp_frame);
                t_valid = 1'b1;
                t_data  = 8'(d);
                t_last  = (k == 47);
                @(posedge clk);
                #1;
                cyc++;
                checkOutput("tput s_ready", 96'(t_ready), 96'(1));
                monitor48();
            end
        end
        t_valid = 1'b0;
        t_last  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            monitor48();
        end
        checkOutput("tput frames seen", 96'(frames_seen), 96'(10));
        checkOutput("tput queue empty", 96'(sb.size()),   96'(0));

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule

// File: doc/layer0_input_packer.md
Name: layer0_input_packer

Overview:
- Input stage directly upstream of the first LUT layer of the HGCAL autoencoder network.
- Accepts a serial stream of per-cell unsigned energy values and quantizes each one to OUT_BW bits using fixed thresholds.
- Packs NUM_FEATURES quantized values into one wide vector and presents it to layer 0 over a valid/ready handshake.
- Double-buffered: assembly of the next frame continues while the previous packed frame waits for the consumer.

Parameters:
- NUM_FEATURES, 48, features per frame (range 2..256).
- IN_W, 8, width of each unsigned input sample.
- OUT_BW, 2, quantized bits per feature. Fixed at 2; the thresholds below define the 4 levels.
- TH0, 64, first quantization threshold (unsigned, IN_W bits).
- TH1, 128, second threshold. Must satisfy TH0 < TH1.
- TH2, 192, third threshold. Must satisfy TH1 < TH2.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  asynchronous active-high reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  packer can accept a sample.
- s_data  in  IN_W  unsigned sample.
- s_last  in  1  marks the final sample of a frame.
- m_valid  out  1  packed frame valid.
- m_ready  in  1  downstream accepts the frame.
- m_data  out  NUM_FEATURES*OUT_BW  packed frame. Feature k sits at bits [k*OUT_BW +: OUT_BW]; feature 0 is the first sample received.
- frame_err  out  1  one-cycle pulse on a framing error.

Behaviour:
- Reset is asynchronous on rst. While rst is high and after its release:
  - s_ready=1, m_valid=0, m_data=0, frame_err=0.
  - Feature counter = 0; assembly register cleared; output buffer empty.
- Quantizer (combinational on s_data):
  - q=0 if s_data<TH0; q=1 if s_data<TH1; q=2 if s_data<TH2; otherwise q=3.
  - A sample equal to a threshold maps to the upper level.
- Input handshake:
  - A sample transfers when s_valid&&s_ready at the clock edge.
  - q is written into assembly slot cnt, then cnt increments.
- Frame completion:
  - A frame completes on the transfer where cnt==NUM_FEATURES-1 and s_last=1.
  - On completion the assembled vector, including that final slot, moves to the output buffer. This happens on the same edge if the buffer is empty, or is simultaneously being drained (m_valid&&m_ready). cnt returns to 0.
  - m_valid rises the cycle after the completing transfer, giving a latency of 1 cycle from the last sample to m_valid.
- States:
  - ASSEMBLE: normal accept.
  - HOLD: frame complete but output buffer occupied and not draining. In HOLD, s_ready=0.
  - Transition HOLD->ASSEMBLE on the edge where m_ready=1. The held frame moves into the buffer, m_valid stays 1 and m_data updates to the new frame.
  - s_ready is registered-free combinational: 1 in ASSEMBLE, 0 in HOLD. It does not depend on m_ready in the same cycle.
- Output handshake:
  - m_data/m_valid are held stable until m_valid&&m_ready.
  - If m_ready is asserted with no frame pending, m_valid drops to 0 the next cycle.
- Framing errors (both cases pulse frame_err for one cycle):
  - s_last=1 with cnt<NUM_FEATURES-1: the partial frame is discarded and cnt resets to 0.
  - cnt==NUM_FEATURES-1 with s_last=0: the sample is accepted, the whole frame is discarded and cnt resets to 0.
  - Neither error case affects the output buffer.
- Back-to-back throughput:
  - With m_ready held high, one sample per cycle is sustained indefinitely.
  - Frames are emitted every NUM_FEATURES cycles with no bubbles.
- Widths: cnt has $clog2(NUM_FEATURES) bits and never wraps, because completion and errors both reset it.
- Reset mid-operation: all partial and buffered frames are lost, outputs return to reset values immediately, and no frame_err is generated.

Test Plan:
- Quantizer boundaries (NUM_FEATURES=4): samples 63,64,191,192 with last on the 4th, m_ready=1 -> m_data=8'b11_10_01_00 one cycle after the 4th sample; m_valid high for exactly 1 cycle.
- Backpressure (NUM_FEATURES=4): frame A=4×200, then frame B=4×0 streamed continuously with m_ready=0 -> m_data=8'hFF held.
  - B's 4th sample is accepted, then s_ready=0 (HOLD).
  - m_ready pulsed one cycle -> next cycle m_data=8'h00, m_valid=1, s_ready=1.
- Short frame (NUM_FEATURES=4): 2 samples with s_last on the 2nd -> frame_err pulse 1 cycle, no m_valid. The following full frame 10,70,130,250 -> m_data=8'b11_10_01_00.
- Missing last (NUM_FEATURES=4): 4 samples with s_last=0 -> frame_err pulse on the 4th transfer, no output. The next valid frame is packed correctly from slot 0.
- Throughput (default NUM_FEATURES=48): 10 frames with s_valid and m_ready tied high -> s_ready never drops; m_valid pulses every 48 cycles; frame contents match a reference model.
- Async reset: assert rst mid-frame (cnt=2) while m_valid=1, asynchronously between clock edges -> m_valid=0 and s_ready=1 before the next edge. After release, a full frame packs from slot 0.
